// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, one-entry fetch buffer toward the decoder,
// redirect handling and out-of-range / misaligned-target fault reporting.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [63:0] if_pc,
    output logic [1:0]  fault_code,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        OOR  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [1:0] FAULT_NONE      = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN  = 2'b01;
    localparam logic [1:0] FAULT_OUT_RANGE = 2'b10;

    state_t      state, state_next;
    logic [63:0] pc, pc_next;
    logic        valid_next;
    logic [31:0] instr_next;
    logic [63:0] if_pc_next;
    logic [1:0]  fault_next;
    logic [31:0] count_next;

    logic handshake;
    logic in_range;
    logic target_aligned;

    assign Inst_Address   = pc;
    assign handshake      = if_valid & id_ready;
    assign in_range       = pc < 64'(MEM_BYTES);
    assign target_aligned = (branch_target[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            if_valid       <= 1'b0;
            if_instruction <= 32'h0;
            if_pc          <= 64'h0;
            fault_code     <= FAULT_NONE;
            fetch_count    <= 32'd0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            if_valid       <= valid_next;
            if_instruction <= instr_next;
            if_pc          <= if_pc_next;
            fault_code     <= fault_next;
            fetch_count    <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        valid_next = if_valid;
        instr_next = if_instruction;
        if_pc_next = if_pc;
        fault_next = fault_code;
        // A handshake counts even when a redirect flushes the buffer in the same cycle.
        count_next = handshake ? fetch_count + 32'd1 : fetch_count;

        case (state)
            BOOT: state_next = RUN;
            RUN, OOR: begin
                if (branch_taken) begin
                    valid_next = 1'b0;
                    if (target_aligned) begin
                        pc_next    = branch_target;
                        state_next = RUN;
                        fault_next = FAULT_NONE;
                    end else begin
                        state_next = HALT;
                        fault_next = FAULT_MISALIGN;
                    end
                end else if (state == RUN && in_range && (!if_valid || id_ready)) begin
                    instr_next = Instruction;
                    if_pc_next = pc;
                    valid_next = 1'b1;
                    pc_next    = pc + 64'd4;
                end else begin
                    // Stall holds everything; a pending word may still drain.
                    if (handshake) valid_next = 1'b0;
                    if (state == RUN && !in_range) begin
                        state_next = OOR;
                        fault_next = FAULT_OUT_RANGE;
                    end
                end
            end
            HALT: valid_next = 1'b0;
            default: state_next = BOOT;
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed stimulus pushes expected
// handshakes into a queue; a negedge monitor pops and compares each handshake.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;
    logic [1:0]  fault_code;
    logic [31:0] fetch_count;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [31:0] count;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [32];

    instruction_fetch_unit #(.RESET_PC(64'd0), .MEM_BYTES(128)) dut (
        .clk            (clk),
        .reset          (reset),
        .Inst_Address   (Inst_Address),
        .Instruction    (Instruction),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .fault_code     (fault_code),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign Instruction = (Inst_Address < 64'd128) ? mem[Inst_Address[6:2]] : 32'hDEAD_BEEF;

    function automatic logic [31:0] word_at(input logic [63:0] addr);
        case (addr)
            64'd0:   return 32'h0000_0B33;
            64'd4:   return 32'h0000_0BB3;
            64'd8:   return 32'h0000_02B3;
            default: return 32'h1000_0000 | addr[31:0];
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] addr, input logic [31:0] cnt);
        exp_t e;
        e.instr = word_at(addr);
        e.pc    = addr;
        e.count = cnt;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change just after posedge, so at negedge they are what the next edge sees.
    always @(negedge clk) begin
        if (!reset && if_valid && id_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL hs_unexpected: got handshake at if_pc %0h expected none", if_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hs_instr", {32'h0, if_instruction}, {32'h0, e.instr});
                chk("hs_pc", if_pc, e.pc);
                chk("hs_count", {32'h0, fetch_count}, {32'h0, e.count});
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = word_at(64'(i * 4));
        reset = 1'b1; branch_taken = 1'b0; branch_target = 64'd0; id_ready = 1'b0;
        tick(); tick();
        chk("rst_addr", Inst_Address, 64'd0);
        chk("rst_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_instr", {32'h0, if_instruction}, 64'd0);
        chk("rst_ifpc", if_pc, 64'd0);
        chk("rst_fault", {62'd0, fault_code}, 64'd0);
        chk("rst_count", {32'h0, fetch_count}, 64'd0);

        // sequential fetch with a 3-cycle stall on the word at 4
        push(64'd0, 32'd0); push(64'd4, 32'd1); push(64'd8, 32'd2); push(64'd12, 32'd3);
        reset = 1'b0; id_ready = 1'b1;
        tick();
        chk("boot_noload", {63'd0, if_valid}, 64'd0);
        tick();
        chk("first_pc", if_pc, 64'd0);
        tick();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", {32'h0, if_instruction}, 64'h0BB3);
            chk("stall_ifpc", if_pc, 64'd4);
            chk("stall_addr", Inst_Address, 64'd8);
            chk("stall_count", {32'h0, fetch_count}, 64'd1);
        end
        id_ready = 1'b1;
        tick(); tick();
        chk("pre_br_pc", if_pc, 64'd12);

        // redirect in the same cycle as a handshake
        push(64'd36, 32'd4);
        for (int a = 40; a <= 124; a += 4) push(64'(a), 32'(4 + (a - 36) / 4));
        branch_taken = 1'b1; branch_target = 64'd36;
        tick();
        branch_taken = 1'b0;
        chk("br_bubble", {63'd0, if_valid}, 64'd0);
        chk("br_count", {32'h0, fetch_count}, 64'd4);
        chk("br_addr", Inst_Address, 64'd36);
        tick();
        chk("br_first_valid", {63'd0, if_valid}, 64'd1);
        chk("br_first_pc", if_pc, 64'd36);

        // run off the end of memory
        begin
            int n = 0;
            while (fault_code != 2'b10 && n < 60) begin tick(); n++; end
        end
        chk("oor_fault", {62'd0, fault_code}, 64'd2);
        chk("oor_last_pc", if_pc, 64'd124);
        chk("oor_valid", {63'd0, if_valid}, 64'd0);
        chk("oor_count", {32'h0, fetch_count}, 64'd27);
        tick(); tick();
        chk("oor_noload", {63'd0, if_valid}, 64'd0);
        chk("oor_count_hold", {32'h0, fetch_count}, 64'd27);

        push(64'd96, 32'd27);
        branch_taken = 1'b1; branch_target = 64'd96;
        tick();
        branch_taken = 1'b0;
        chk("resume_fault", {62'd0, fault_code}, 64'd0);
        chk("resume_bubble", {63'd0, if_valid}, 64'd0);
        tick();
        chk("resume_pc", if_pc, 64'd96);
        tick();
        id_ready = 1'b0;
        chk("resume_next_pc", if_pc, 64'd100);

        // misaligned target -> HALT, then a later branch is ignored
        branch_taken = 1'b1; branch_target = 64'd6;
        tick();
        chk("mis_fault", {62'd0, fault_code}, 64'd1);
        chk("mis_valid", {63'd0, if_valid}, 64'd0);
        chk("mis_addr", Inst_Address, 64'd104);
        chk("mis_count", {32'h0, fetch_count}, 64'd28);
        branch_target = 64'd0; id_ready = 1'b1;
        tick(); tick();
        chk("halt_fault", {62'd0, fault_code}, 64'd1);
        chk("halt_addr", Inst_Address, 64'd104);
        chk("halt_valid", {63'd0, if_valid}, 64'd0);
        branch_taken = 1'b0; reset = 1'b1;
        tick();
        chk("halt_rst_addr", Inst_Address, 64'd0);
        chk("halt_rst_fault", {62'd0, fault_code}, 64'd0);
        chk("halt_rst_count", {32'h0, fetch_count}, 64'd0);

        // reset wins over a simultaneous redirect
        reset = 1'b0; id_ready = 1'b0;
        tick(); tick(); tick();
        chk("stall_valid", {63'd0, if_valid}, 64'd1);
        reset = 1'b1; branch_taken = 1'b1; branch_target = 64'd40;
        tick();
        chk("rstbr_addr", Inst_Address, 64'd0);
        chk("rstbr_valid", {63'd0, if_valid}, 64'd0);
        chk("rstbr_ifpc", if_pc, 64'd0);
        reset = 1'b0; branch_taken = 1'b0;
        tick();
        chk("rstbr_boot", {63'd0, if_valid}, 64'd0);
        chk("rstbr_boot_addr", Inst_Address, 64'd0);
        tick();
        chk("rstbr_run_valid", {63'd0, if_valid}, 64'd1);
        chk("rstbr_run_pc", if_pc, 64'd0);

        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", checks - errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'd0: the PC value loaded on reset.
REQ-002 The block SHALL have parameter MEM_BYTES, default 128: instruction memory size in bytes; addresses >= MEM_BYTES are out of range.
REQ-003 The block SHALL have a single clock domain and a synchronous, active-high reset, with ports as follows.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Inst_Address  output  64  byte address to instruction memory; always equals the PC register (combinational).
REQ-007 Instruction  input  32  word returned combinationally by instruction memory for Inst_Address.
REQ-008 branch_taken  input  1  one-cycle redirect request from the downstream stage.
REQ-009 branch_target  input  64  redirect byte address; valid only while branch_taken=1.
REQ-010 id_ready  input  1  the downstream decoder can accept a word this cycle.
REQ-011 if_valid  output  1  if_instruction and if_pc hold a fetched word.
REQ-012 if_instruction  output  32  registered instruction word.
REQ-013 if_pc  output  64  address the registered word was fetched from.
REQ-014 fault_code  output  2  2'b00 none, 2'b01 misaligned target, 2'b10 PC out of range.
REQ-015 fetch_count  output  32  number of completed handshakes; wraps modulo 2^32.

Function
REQ-016 The block SHALL implement states BOOT, RUN, OOR and HALT.
REQ-017 A handshake SHALL complete in a cycle where if_valid=1 and id_ready=1.
REQ-018 BOOT SHALL last exactly one cycle with no load, then move to RUN.
REQ-019 In RUN with PC < MEM_BYTES and (if_valid=0 or id_ready=1), the block SHALL perform a load at the clock edge:
- if_instruction <= Instruction
- if_pc <= PC
- if_valid <= 1
- PC <= PC + 4
REQ-020 In RUN with if_valid=1 and id_ready=0 (stall), if_instruction, if_pc, if_valid and PC SHALL hold their values unchanged.
REQ-021 In RUN with PC >= MEM_BYTES, the block SHALL move to OOR without loading.
REQ-022 In OOR the block SHALL perform no loads and SHALL drive fault_code=2'b10.
REQ-023 In OOR, if_valid SHALL clear after any pending word completes its handshake.
REQ-024 When branch_taken=1 in RUN or OOR with branch_target[1:0]=2'b00, the block SHALL flush and redirect:
- if_valid <= 0
- PC <= branch_target
- state <= RUN
- fault_code <= 2'b00
REQ-025 A redirect SHALL take priority over load and stall in the same cycle.
REQ-026 When branch_taken=1 in RUN or OOR with branch_target[1:0]!=2'b00, the block SHALL:
- leave PC unchanged
- set if_valid <= 0
- set fault_code <= 2'b01
- enter HALT.
REQ-027 HALT SHALL be exited only by reset; in HALT, loads and branch_taken SHALL be ignored and if_valid SHALL remain 0.
REQ-028 fetch_count SHALL increment on every completed handshake, including a handshake in the same cycle as a redirect.
REQ-029 The first word of a redirect SHALL appear with if_valid=1 on the edge after the redirect edge (one-cycle bubble).
REQ-030 PC arithmetic SHALL be 64-bit unsigned; PC+4 SHALL wrap modulo 2^64.
REQ-031 A redirect SHALL NOT by itself trigger an out-of-range check; the check SHALL apply on the next RUN cycle.

Reset
REQ-032 The reset values SHALL be:
- PC=RESET_PC
- state=BOOT
- if_valid=0
- if_instruction=32'h0
- if_pc=64'h0
- fault_code=2'b00
- fetch_count=0
REQ-033 Reset SHALL override all other inputs in the same cycle, including branch_taken and id_ready.
REQ-034 Reset asserted mid-stall, in OOR or in HALT SHALL fully restore the REQ-032 values in one edge.

Verification
REQ-035 The bench SHALL cover: reset, then id_ready=1 with memory words 0x00000B33@0, 0x00000BB3@4, 0x000002B3@8 -> if_instruction sequence 00000B33, 00000BB3, 000002B3; if_pc sequence 0, 4, 8; fetch_count 0, 1, 2.
REQ-036 The bench SHALL cover: id_ready=0 for 3 cycles while if_valid=1 at if_pc=4 -> if_instruction=00000BB3, if_pc=4 and Inst_Address=8 all held; fetch_count unchanged.
REQ-037 The bench SHALL cover: branch_taken=1 with branch_target=64'd36 while if_valid=1 and id_ready=1 -> fetch_count increments; next cycle if_valid=0; following cycle if_pc=36, if_valid=1.
REQ-038 The bench SHALL cover: sequential run to PC=128 with MEM_BYTES=128 -> last word if_pc=124; fault_code=2'b10; no further loads; then branch_taken with target 96 -> fault_code=2'b00 and fetch resumes at if_pc=96.
REQ-039 The bench SHALL cover: branch_taken with branch_target=64'd6 -> fault_code=2'b01 and if_valid=0; subsequent branch_taken with target 0 is ignored; reset restores PC=0 and fault_code=2'b00.
REQ-040 The bench SHALL cover: reset asserted in the same cycle as branch_taken=1 with target 40 -> PC=RESET_PC and state=BOOT; the target is ignored.
